// File: rtl/riscv_branch_pkg.sv
// rtl/riscv_branch_pkg.sv - shared branch types, FSM states and defaults
// Purpose: types shared by the branch resolve arbiter and its comparator.
// Contents: br_type_e (funct3 branch codes), br_state_e (arbiter FSM),
//           BR_TAG_W (default branch tag width).
package riscv_branch_pkg;

  localparam int BR_TAG_W = 4;

  // funct3 codes; 2 and 3 are not branches and resolve as illegal.
  typedef enum logic [2:0] {
    BR_BEQ  = 3'd0,
    BR_BNE  = 3'd1,
    BR_RSV2 = 3'd2,
    BR_RSV3 = 3'd3,
    BR_BLT  = 3'd4,
    BR_BGE  = 3'd5,
    BR_BLTU = 3'd6,
    BR_BGEU = 3'd7
  } br_type_e;

  // IDLE: output empty, HOLD: result held, BLOCK: mispredict consumed, waiting for flush.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_BLOCK = 2'd2
  } br_state_e;

endpackage

// File: rtl/branch_cmp.sv
// rtl/branch_cmp.sv - combinational branch condition evaluator
// Purpose: evaluates one branch condition on two 32-bit operands.
// Ports: a_i, b_i    operands (rs1, rs2)
//        type_i      funct3 branch code
//        taken_o     condition true (0 for illegal codes)
//        illegal_o   code is not a branch (2 or 3)
module branch_cmp
  import riscv_branch_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [2:0]  type_i,
  output logic        taken_o,
  output logic        illegal_o
);

  logic [32:0] diff;
  logic        eq;
  logic        ltu;
  logic        lts;

  // The borrow of a 33-bit subtract is the unsigned less-than. For the signed
  // compare, differing sign bits decide directly; equal signs reduce to unsigned.
  assign diff = {1'b0, a_i} - {1'b0, b_i};
  assign eq   = (a_i == b_i);
  assign ltu  = diff[32];
  assign lts  = (a_i[31] ^ b_i[31]) ? a_i[31] : ltu;

  always_comb begin
    taken_o   = 1'b0;
    illegal_o = 1'b0;
    case (br_type_e'(type_i))
      BR_BEQ:  taken_o = eq;
      BR_BNE:  taken_o = !eq;
      BR_BLT:  taken_o = lts;
      BR_BGE:  taken_o = !lts;
      BR_BLTU: taken_o = ltu;
      BR_BGEU: taken_o = !ltu;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_arbiter.sv
// rtl/branch_resolve_arbiter.sv - two-lane branch resolver sharing one comparator
// Purpose: accepts branch requests from two lanes (lane 0 older, fixed priority),
//          resolves them on a single shared comparator and holds one result
//          until consumed. A consumed mispredict blocks until flush.
// Ports: clk, rst_n (async active-low)
//        req0_*/req1_*  valid/ready, operands a/b, funct3 type, pred, tag
//        flush          frontend flush, overrides grant and res_ready
//        res_*          result valid/ready, taken, mispred, illegal, lane, tag
//        stat_resolved, stat_mispred  only with BRANCH_RESOLVE_STATS_EN defined
module branch_resolve_arbiter
  import riscv_branch_pkg::*;
#(
  parameter int TAG_W = BR_TAG_W,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [2:0]       req0_type,
  input  logic             req0_pred,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [2:0]       req1_type,
  input  logic             req1_pred,
  input  logic [TAG_W-1:0] req1_tag,
  input  logic             flush,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_taken,
  output logic             res_mispred,
  output logic             res_illegal,
  output logic             res_lane,
`ifdef BRANCH_RESOLVE_STATS_EN
  output logic [CNT_W-1:0] stat_resolved,
  output logic [CNT_W-1:0] stat_mispred,
`endif
  output logic [TAG_W-1:0] res_tag
);

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  br_state_e        state_q;
  logic             res_valid_q;
  logic             res_taken_q;
  logic             res_mispred_q;
  logic             res_illegal_q;
  logic             res_lane_q;
  logic [TAG_W-1:0] res_tag_q;

  logic             accept_ok;
  logic             grant;
  logic             sel_lane1;
  logic             consume;
  logic [31:0]      cmp_a;
  logic [31:0]      cmp_b;
  logic [2:0]       cmp_type;
  logic             sel_pred;
  logic [TAG_W-1:0] sel_tag;
  logic             cmp_taken;
  logic             cmp_illegal;

  // A new request fits only when the output slot is empty or is being drained
  // by a non-mispredicted result. rst_n gates the readies while reset is held.
  assign accept_ok  = rst_n && !flush &&
                      ((state_q == ST_IDLE) ||
                       (state_q == ST_HOLD && res_ready && !res_mispred_q));
  assign req0_ready = accept_ok;
  assign req1_ready = accept_ok && !req0_valid;
  assign grant      = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  // Lane 1 only reaches the comparator when lane 0 has nothing to offer.
  assign sel_lane1 = !req0_valid;
  assign cmp_a     = sel_lane1 ? req1_a    : req0_a;
  assign cmp_b     = sel_lane1 ? req1_b    : req0_b;
  assign cmp_type  = sel_lane1 ? req1_type : req0_type;
  assign sel_pred  = sel_lane1 ? req1_pred : req0_pred;
  assign sel_tag   = sel_lane1 ? req1_tag  : req0_tag;

  branch_cmp u_cmp (
    .a_i       (cmp_a),
    .b_i       (cmp_b),
    .type_i    (cmp_type),
    .taken_o   (cmp_taken),
    .illegal_o (cmp_illegal)
  );

  // A held result dropped by flush is never counted as consumed.
  assign consume = (state_q == ST_HOLD) && res_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      res_valid_q   <= 1'b0;
      res_taken_q   <= 1'b0;
      res_mispred_q <= 1'b0;
      res_illegal_q <= 1'b0;
      res_lane_q    <= 1'b0;
      res_tag_q     <= '0;
    end else if (flush) begin
      state_q     <= ST_IDLE;
      res_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant) begin
            state_q     <= ST_HOLD;
            res_valid_q <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (res_ready) begin
            if (res_mispred_q) begin
              state_q     <= ST_BLOCK;
              res_valid_q <= 1'b0;
            end else if (!grant) begin
              state_q     <= ST_IDLE;
              res_valid_q <= 1'b0;
            end
          end
        end
        ST_BLOCK: begin
          state_q     <= ST_BLOCK;
          res_valid_q <= 1'b0;
        end
        default: begin
          state_q     <= ST_IDLE;
          res_valid_q <= 1'b0;
        end
      endcase
      // grant implies IDLE or a draining HOLD, so the slot is free to reload.
      if (grant) begin
        res_taken_q   <= cmp_taken;
        res_mispred_q <= cmp_taken ^ sel_pred;
        res_illegal_q <= cmp_illegal;
        res_lane_q    <= sel_lane1;
        res_tag_q     <= sel_tag;
      end
    end
  end

  assign res_valid   = res_valid_q;
  assign res_taken   = res_taken_q;
  assign res_mispred = res_mispred_q;
  assign res_illegal = res_illegal_q;
  assign res_lane    = res_lane_q;
  assign res_tag     = res_tag_q;

`ifdef BRANCH_RESOLVE_STATS_EN
  logic [CNT_W-1:0] stat_resolved_q;
  logic [CNT_W-1:0] stat_mispred_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_resolved_q <= '0;
      stat_mispred_q  <= '0;
    end else if (consume) begin
      stat_resolved_q <= stat_resolved_q + CNT_W'(1);
      if (res_mispred_q) begin
        stat_mispred_q <= stat_mispred_q + CNT_W'(1);
      end
    end
  end

  assign stat_resolved = stat_resolved_q;
  assign stat_mispred  = stat_mispred_q;
`else
  logic unused_consume;
  assign unused_consume = consume;
`endif

endmodule

// File: doc/branch_resolve_arbiter.md
BRANCH_RESOLVE_ARBITER -- requirements
Module: branch_resolve_arbiter

Interface
REQ-001 SHALL have parameter TAG_W, default 4: width of the branch tag carried with each request.
REQ-002 SHALL have parameter CNT_W, default 32: width of the statistics counters.
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports reqN_valid  in  1, reqN_ready  out  1, for N=0,1: per-lane request handshake; lane 0 is older.
REQ-006 SHALL have ports reqN_a, reqN_b  in  32 each: rs1/rs2 operand values.
REQ-007 SHALL have port reqN_type  in  3  funct3 code: 0 beq, 1 bne, 4 blt, 5 bge, 6 bltu, 7 bgeu.
REQ-008 SHALL have ports reqN_pred  in  1 (predicted taken) and reqN_tag  in  TAG_W.
REQ-009 SHALL have port flush  in  1  pipeline flush from the frontend.
REQ-010 SHALL have ports res_valid  out  1, res_ready  in  1: result handshake.
REQ-011 SHALL have ports res_taken, res_mispred, res_illegal, res_lane  out  1 each, and res_tag  out  TAG_W.

Function
REQ-012 SHALL instantiate exactly one comparator and share it between both lanes.
REQ-013 SHALL use FSM states IDLE (output empty), HOLD (result held), and BLOCK (mispredict seen, awaiting flush).
REQ-014 SHALL grant at most one request per cycle: reqN_ready=1 only when the state is IDLE, or HOLD with res_ready=1 and the held result not mispredicted.
REQ-015 SHALL use fixed priority, lane 0 over lane 1: req1_ready=0 whenever req0_valid=1.
REQ-016 SHALL treat a grant as reqN_valid&&reqN_ready, and SHALL register the result at that edge: 1-cycle latency, res_valid high the next cycle.
REQ-017 SHALL compute res_taken per REQ-007, using signed comparison for codes 4/5 and unsigned for 6/7.
REQ-018 SHALL, for codes 2 or 3, set res_illegal=1, res_taken=0, and res_mispred=reqN_pred.
REQ-019 SHALL set res_mispred=res_taken XOR reqN_pred.
REQ-020 SHALL copy reqN_tag to res_tag, and SHALL set res_lane=N.
REQ-021 SHALL keep all res_* outputs stable while res_valid=1 and res_ready=0.
REQ-022 SHALL implement these transitions: IDLE+grant -> HOLD; HOLD+res_ready without grant -> IDLE; HOLD+res_ready with grant -> HOLD.
REQ-023 SHALL go to BLOCK when a result with res_mispred=1 is consumed; in BLOCK all readies SHALL be 0 and res_valid SHALL be 0.
REQ-024 SHALL, on flush=1 in any state, clear res_valid, go to IDLE, and deassert all readies that cycle; flush SHALL take priority over grant and res_ready.
REQ-025 SHALL drop a held result on flush even if res_ready=1 in the same cycle; that result SHALL count as not consumed.

Reset
REQ-026 SHALL, on rst_n=0, immediately enter IDLE and clear res_valid, res_taken, res_mispred, res_illegal, res_lane, res_tag and all counters to 0, regardless of any transfer in progress.
REQ-027 SHALL keep readies at 0 while rst_n=0, and SHALL grant on the first edge after release.

Configuration
REQ-028 SHALL, with macro BRANCH_RESOLVE_STATS_EN defined, add output ports stat_resolved and stat_mispred (CNT_W each).
REQ-029 SHALL increment these counters on each consumed result and each consumed mispredict respectively, wrapping modulo 2^CNT_W.
REQ-030 SHALL, without BRANCH_RESOLVE_STATS_EN, omit those ports and counters, with all other behaviour identical.

Structure
REQ-031 SHALL place the branch-type enum, the FSM state enum and the TAG_W default in shared package riscv_branch_pkg.
REQ-032 SHALL implement the comparator as sub-module branch_cmp (purely combinational), fed by a lane-select mux.

Verification
REQ-033 SHALL verify: req0 bltu a=1, b=0xFFFFFFFF, pred=0 -> next cycle res_valid=1, taken=1, mispred=1, lane=0; after consumption, BLOCK with readies 0 until flush.
REQ-034 SHALL verify: req0 and req1 both valid (beq 5==5 and bne 3!=4), pred=1 -> lane 0 result first, lane 1 the following cycle; neither mispredicts.
REQ-035 SHALL verify: blt a=0x80000000, b=1, pred=1 -> taken=1, mispred=0; then bge with the same operands -> taken=0.
REQ-036 SHALL verify: res_ready=0 for 3 cycles with req1 valid -> outputs stable and req1_ready=0; after res_ready=1, req1 is granted that same cycle.
REQ-037 SHALL verify: type=2, pred=1 -> res_illegal=1, taken=0, mispred=1; with the stats macro, stat_resolved=1 and stat_mispred=1.
REQ-038 SHALL verify: flush with a result held and res_ready=1 -> res_valid=0 next cycle, IDLE, counters unchanged; rst_n low mid-HOLD -> all outputs 0 asynchronously.
